// File: rtl/atctlc2axi500_pkg.sv
// Shared definitions for the AXI-side binary-to-mask decode pipeline.
// Mode encodings select the mask shape produced for each lane.
package atctlc2axi500_pkg;

    localparam logic [1:0] MODE_ONEHOT = 2'd0;
    localparam logic [1:0] MODE_LTHERM = 2'd1;
    localparam logic [1:0] MODE_UTHERM = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

endpackage

// File: rtl/atctlc2axi500_bin2mask_lane.sv
// Combinational decode of one lane index into a one-hot or thermometer mask.
// An out-of-range index or the reserved mode yields an all-zero mask with err set.
module atctlc2axi500_bin2mask_lane
    import atctlc2axi500_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] idx,
    input  logic [1:0]   mode,
    output logic [N-1:0] mask,
    output logic         err
);

    always_comb begin
        mask = '0;
        err  = 1'b0;
        if (mode == MODE_RSVD || int'(idx) >= N) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    MODE_ONEHOT: mask[i] = (i == int'(idx));
                    MODE_LTHERM: mask[i] = (i <= int'(idx));
                    MODE_UTHERM: mask[i] = (i >= int'(idx));
                    default:     mask[i] = 1'b0;
                endcase
            end
        end
    end

endmodule

// File: rtl/atctlc2axi500_bin2onehot_pipe.sv
// Multi-lane registered binary-to-mask decoder with an output register plus a
// one-entry skid so in_ready is a pure register output.
module atctlc2axi500_bin2onehot_pipe #(
    parameter int N   = 8,
    parameter int NCH = 4,
    parameter int CW  = 8,
    localparam int W  = $clog2(N)
) (
    input  logic               aclk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCH*W-1:0]   in_idx,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCH*N-1:0]   out_mask,
    output logic [NCH-1:0]     out_err,
    output logic [CW-1:0]      err_cnt,
    input  logic               err_cnt_clr
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [NCH*N-1:0] dec_mask;
    logic [NCH-1:0]   dec_err;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        atctlc2axi500_bin2mask_lane #(.N(N)) u_lane (
            .idx  (in_idx[k*W +: W]),
            .mode (in_mode),
            .mask (dec_mask[k*N +: N]),
            .err  (dec_err[k])
        );
    end

    logic             out_valid_q, out_valid_d;
    logic [NCH*N-1:0] out_mask_q,  out_mask_d;
    logic [NCH-1:0]   out_err_q,   out_err_d;
    logic             skid_full_q, skid_full_d;
    logic [NCH*N-1:0] skid_mask_q, skid_mask_d;
    logic [NCH-1:0]   skid_err_q,  skid_err_d;
    logic [CW-1:0]    err_cnt_q,   err_cnt_d;

    logic accept;
    logic out_free;

    assign accept   = in_valid & ~skid_full_q;
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_err_d   = out_err_q;
        skid_full_d = skid_full_q;
        skid_mask_d = skid_mask_q;
        skid_err_d  = skid_err_q;
        err_cnt_d   = err_cnt_q;

        // A full skid always drains first so beats leave in acceptance order.
        if (out_free) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_mask_d  = skid_mask_q;
                out_err_d   = skid_err_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_mask_d  = dec_mask;
                out_err_d   = dec_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_mask_d = dec_mask;
            skid_err_d  = dec_err;
        end

        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (accept && (|dec_err) && err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_err_q   <= '0;
            skid_full_q <= 1'b0;
            skid_mask_q <= '0;
            skid_err_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_err_q   <= out_err_d;
            skid_full_q <= skid_full_d;
            skid_mask_q <= skid_mask_d;
            skid_err_q  <= skid_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = ~skid_full_q;
    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_atctlc2axi500_bin2onehot_pipe.sv
// Drives an N=8/CW=8 and an N=6/CW=2 instance in lockstep and compares both
// against an arithmetic decode model with a queue of in-flight beats.
module tb_atctlc2axi500_bin2onehot_pipe;

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_idx = '0;
    logic [1:0]  in_mode = '0;
    logic        out_ready = 1'b0;
    logic        err_cnt_clr = 1'b0;

    logic        rdy8, vld8, rdy6, vld6;
    logic [31:0] mask8;
    logic [23:0] mask6;
    logic [3:0]  err8, err6;
    logic [7:0]  cnt8;
    logic [1:0]  cnt6;

    always #5 aclk = ~aclk;

    atctlc2axi500_bin2onehot_pipe #(.N(8), .NCH(4), .CW(8)) dut8 (
        .aclk(aclk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8),
        .in_idx(in_idx), .in_mode(in_mode), .out_valid(vld8), .out_ready(out_ready),
        .out_mask(mask8), .out_err(err8), .err_cnt(cnt8), .err_cnt_clr(err_cnt_clr)
    );

    atctlc2axi500_bin2onehot_pipe #(.N(6), .NCH(4), .CW(2)) dut6 (
        .aclk(aclk), .reset(reset), .in_valid(in_valid), .in_ready(rdy6),
        .in_idx(in_idx), .in_mode(in_mode), .out_valid(vld6), .out_ready(out_ready),
        .out_mask(mask6), .out_err(err6), .err_cnt(cnt6), .err_cnt_clr(err_cnt_clr)
    );

    typedef struct packed {
        logic [31:0] m8;
        logic [3:0]  e8;
        logic [23:0] m6;
        logic [3:0]  e6;
    } beat_t;

    beat_t q[$];
    int    ref_cnt8 = 0;
    int    ref_cnt6 = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dec_ref(input int n, input int idx, input int mode);
        int full;
        int r;
        full = (1 << n) - 1;
        if (mode == 3 || idx >= n) r = 0;
        else if (mode == 0) r = (1 << idx) & full;
        else if (mode == 1) r = ((2 << idx) - 1) & full;
        else r = (~((1 << idx) - 1)) & full;
        return r[7:0];
    endfunction

    function automatic beat_t make_beat(input logic [11:0] idx, input logic [1:0] mode);
        beat_t b;
        logic [7:0] m;
        int ik;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            ik = int'(idx[k*3 +: 3]);
            m = dec_ref(8, ik, int'(mode));
            b.m8[k*8 +: 8] = m;
            b.e8[k] = (mode == 2'd3);
            m = dec_ref(6, ik, int'(mode));
            b.m6[k*6 +: 6] = m[5:0];
            b.e6[k] = (mode == 2'd3) || (ik >= 6);
        end
        return b;
    endfunction

    task automatic check_state();
        chk_eq("vld8", vld8, q.size() > 0);
        chk_eq("vld6", vld6, q.size() > 0);
        chk_eq("rdy8", rdy8, q.size() < 2);
        chk_eq("rdy6", rdy6, q.size() < 2);
        chk_eq("cnt8", cnt8, ref_cnt8);
        chk_eq("cnt6", cnt6, ref_cnt6);
        if (q.size() > 0) begin
            chk_eq("mask8", mask8, q[0].m8);
            chk_eq("err8",  err8,  q[0].e8);
            chk_eq("mask6", mask6, q[0].m6);
            chk_eq("err6",  err6,  q[0].e6);
        end
    endtask

    // One clock: check outputs settled from the last edge, drive, then advance the model.
    task automatic step(input logic v, input logic [11:0] idx, input logic [1:0] mode,
                        input logic ordy, input logic clr, input logic rst);
        beat_t b;
        logic  acc;
        @(negedge aclk);
        check_state();
        in_valid    = v;
        in_idx      = idx;
        in_mode     = mode;
        out_ready   = ordy;
        err_cnt_clr = clr;
        reset       = rst;
        if (rst) begin
            q.delete();
            ref_cnt8 = 0;
            ref_cnt6 = 0;
        end else begin
            b   = make_beat(idx, mode);
            acc = v && (q.size() < 2);
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (acc) q.push_back(b);
            if (clr) begin
                ref_cnt8 = 0;
                ref_cnt6 = 0;
            end else if (acc) begin
                if ((|b.e8) && ref_cnt8 < 255) ref_cnt8++;
                if ((|b.e6) && ref_cnt6 < 3) ref_cnt6++;
            end
        end
    endtask

    task automatic after_edge();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int sat_exp[5];
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

        repeat (2) @(posedge aclk);
        step(1'b0, 12'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        chk_eq("rst_mask8", mask8, 0);
        chk_eq("rst_err8", err8, 0);
        chk_eq("rst_rdy8", rdy8, 1);

        // Basic decode, lanes {7,0,3,5}
        step(1'b1, {3'd5, 3'd3, 3'd0, 3'd7}, 2'd0, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk_eq("basic_vld", vld8, 1);
        chk_eq("basic_mask", mask8, 32'h2008_0180);
        chk_eq("basic_err", err8, 0);

        // Mode sweep, lane 0 idx 3
        step(1'b1, 12'd3, 2'd1, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk_eq("lth_mask", mask8[7:0], 8'h0F);
        step(1'b1, 12'd3, 2'd2, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk_eq("uth_mask", mask8[7:0], 8'hF8);
        chk_eq("cnt_pre", cnt8, 0);
        step(1'b1, 12'd3, 2'd3, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk_eq("rsv_mask", mask8, 0);
        chk_eq("rsv_err", err8, 4'hF);
        chk_eq("rsv_cnt", cnt8, 1);

        // Out-of-range on the N=6 instance, lanes {6,7,5,0}
        step(1'b0, 12'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, {3'd0, 3'd5, 3'd7, 3'd6}, 2'd0, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk_eq("oor_mask6", mask6, 24'h06_0000);
        chk_eq("oor_err6", err6, 4'b0011);
        chk_eq("oor_cnt6", cnt6, 1);
        chk_eq("oor_mask8", mask8, 32'h0120_8040);

        // Backpressure A, B, C then release
        step(1'b0, 12'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'o0123, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'o4567, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'o2222, 2'd2, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk_eq("bp_rdy_low", rdy8, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 12'o2222, 2'd2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 12'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Saturation on the CW=2 instance
        step(1'b0, 12'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 12'h0, 2'd3, 1'b1, 1'b0, 1'b0);
            after_edge();
            chk_eq("sat_cnt6", cnt6, sat_exp[i]);
        end
        step(1'b1, 12'h0, 2'd3, 1'b1, 1'b1, 1'b0);
        after_edge();
        chk_eq("sat_clr", cnt6, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 12'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 4) < 3, $urandom_range(0, 19) == 0, 1'b0);
        end

        // Reset with output and skid both full
        step(1'b1, 12'o1357, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'o7531, 2'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 12'o1111, 2'd1, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk_eq("pre_rst_rdy", rdy8, 0);
        step(1'b0, 12'h0, 2'd0, 1'b0, 1'b0, 1'b1);
        after_edge();
        chk_eq("post_rst_vld", vld8, 0);
        chk_eq("post_rst_rdy", rdy8, 1);
        chk_eq("post_rst_cnt", cnt8, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 12'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step($urandom_range(0, 1) != 0, 12'($urandom), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) != 0, 1'b0, 1'b0);
        end
        @(negedge aclk);
        check_state();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
